// File: rtl/rv32_pkg_mem.sv
// Shared definitions for the rv32 memory-port arbiter.
// Contents:
//   arb_state_t    - arbiter FSM state encoding
//   ARB_OWNER_IF   - owner code for instruction fetch
//   ARB_OWNER_LS   - owner code for load/store
//   MEM_WIDTH_WORD - bus width code used for every fetch
package rv32_pkg_mem;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_LS = 2'd2
    } arb_state_t;

    localparam logic ARB_OWNER_IF = 1'b0;
    localparam logic ARB_OWNER_LS = 1'b1;

    localparam logic [3:0] MEM_WIDTH_WORD = 4'b0010;

endpackage

// File: rtl/rv32_mod_bus_watchdog.sv
// Bus watchdog for the memory arbiter.
// A cycle counter that clears while `clear` is high and counts up
// while `enable` is high. `expired` is raised in the cycle that would be
// the TIMEOUT_CYCLES-th counted cycle.
// This lets the arbiter abandon the grant in that same cycle.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count (arbiter idle)
//   enable    - count this cycle (grant held, no completion)
//   expired   - limit reached this cycle
module rv32_mod_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] ONE   = 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + ONE;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/rv32_mod_mem_arbiter.sv
// Two-requester arbiter sharing the rv32imc_ss RAM/IO port between
// instruction fetch (IF) and load/store (LS). The winning request is
// registered onto the bus at grant and held until mem_ack. The response
// is routed combinationally to the owner in the ack cycle.
// Optional feature: define RV32_ARB_TIMEOUT_EN to add a watchdog. The
// watchdog terminates a grant with an error after TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   if_req/if_addr                  - fetch request
//   if_rdata/if_ack/if_err          - fetch response
//   ls_req/ls_wr/ls_width/ls_addr/ls_wdata - load/store request
//   ls_rdata/ls_ack/ls_err          - load/store response
//   mem_req/mem_wr/mem_width/mem_addr/mem_wdata - bus request (registered)
//   mem_rdata/mem_ack/mem_err       - bus response
//   busy                            - transaction in flight
//   owner                           - current/last grant (0 IF, 1 LS)
module rv32_mod_mem_arbiter
    import rv32_pkg_mem::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    output logic                  if_err,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [3:0]            ls_width,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_ack,
    output logic                  ls_err,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [3:0]            mem_width,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    input  logic                  mem_err,
    output logic                  busy,
    output logic                  owner
);

    arb_state_t state;
    logic       in_grant;
    logic       timeout;
    logic       done;
    logic       grant_ls;
    logic       grant_if;

    assign in_grant = (state != IDLE);

`ifdef RV32_ARB_TIMEOUT_EN
    rv32_mod_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_grant),
        .enable  (in_grant && !mem_ack),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // A real completion outranks a timeout in the same cycle.
    assign done = in_grant && (mem_ack || timeout);

    // Round robin: on contention, favour whoever did not win last.
    assign grant_ls = ls_req && (!if_req || owner == ARB_OWNER_IF);
    assign grant_if = if_req && !grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= ARB_OWNER_IF;
            mem_wr    <= 1'b0;
            mem_width <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        state     <= GNT_LS;
                        owner     <= ARB_OWNER_LS;
                        mem_wr    <= ls_wr;
                        mem_width <= ls_width;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                    end else if (grant_if) begin
                        state     <= GNT_IF;
                        owner     <= ARB_OWNER_IF;
                        mem_wr    <= 1'b0;
                        mem_width <= MEM_WIDTH_WORD;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                GNT_IF, GNT_LS: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req = in_grant;
    assign busy    = in_grant;

    always_comb begin
        if_ack   = 1'b0;
        if_err   = 1'b0;
        if_rdata = '0;
        ls_ack   = 1'b0;
        ls_err   = 1'b0;
        ls_rdata = '0;
        if (done) begin
            if (state == GNT_IF) begin
                if_ack   = 1'b1;
                if_err   = mem_ack ? mem_err : 1'b1;
                if_rdata = mem_ack ? mem_rdata : '0;
            end else begin
                ls_ack   = 1'b1;
                ls_err   = mem_ack ? mem_err : 1'b1;
                ls_rdata = mem_ack ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
module tb_rv32_mod_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;
    logic        ls_req;
    logic        ls_wr;
    logic [3:0]  ls_width;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        ls_err;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        busy;
    logic        owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32_mod_mem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_wr     (ls_wr),
        .ls_width  (ls_width),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .ls_ack    (ls_ack),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_width (mem_width),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err),
        .busy      (busy),
        .owner     (owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_wr = 0; ls_width = '0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0; mem_ack = 0; mem_err = 0;
        step(); step();
        settle();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_owner",   32'(owner),   0);
        rst = 1'b0;
        step();

        // IF alone, ack 3 cycles after mem_req rises
        if_req = 1; if_addr = 32'h100;
        step(); settle();
        chk("if_mem_req",   32'(mem_req), 1);
        chk("if_mem_addr",  mem_addr, 32'h100);
        chk("if_mem_width", 32'(mem_width), 32'h2);
        chk("if_mem_wr",    32'(mem_wr), 0);
        chk("if_owner",     32'(owner), 0);
        step(); step();
        settle();
        chk("if_wait_ack",   32'(if_ack), 0);
        chk("if_wait_rdata", if_rdata, 0);
        step();
        mem_ack = 1; mem_rdata = 32'h13;
        settle();
        chk("if_ack",       32'(if_ack), 1);
        chk("if_rdata",     if_rdata, 32'h13);
        chk("if_err",       32'(if_err), 0);
        chk("if_ls_ack",    32'(ls_ack), 0);
        step();
        mem_ack = 0; if_req = 0; mem_rdata = '0;
        settle();
        chk("if_done_req",  32'(mem_req), 0);
        chk("if_done_ack",  32'(if_ack), 0);

        // Contention: owner is IF, so alternation starts with LS
        if_req = 1; if_addr = 32'h200;
        ls_req = 1; ls_wr = 0; ls_width = 4'h2; ls_addr = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            step(); settle();
            chk("rr_mem_req", 32'(mem_req), 1);
            chk("rr_owner",   32'(owner), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_addr",    mem_addr, (i % 2 == 0) ? 32'h3000 : 32'h200);
            mem_ack = 1; mem_rdata = 32'hA0 + 32'(i);
            settle();
            chk("rr_ls_ack",  32'(ls_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_if_ack",  32'(if_ack), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            mem_ack = 0;
            if (i == 3) begin
                if_req = 0; ls_req = 0;
            end
            settle();
            chk("rr_gap", 32'(mem_req), 0);
        end

        // Store with bus error; payload change while waiting is ignored
        ls_req = 1; ls_wr = 1; ls_width = 4'h1; ls_addr = 32'h2002; ls_wdata = 32'hBEEF;
        step(); settle();
        chk("st_wr",    32'(mem_wr), 1);
        chk("st_width", 32'(mem_width), 32'h1);
        chk("st_addr",  mem_addr, 32'h2002);
        chk("st_wdata", mem_wdata, 32'hBEEF);
        ls_addr = 32'hDEAD;
        step(); settle();
        chk("st_hold_addr", mem_addr, 32'h2002);
        mem_ack = 1; mem_err = 1;
        settle();
        chk("st_ls_ack", 32'(ls_ack), 1);
        chk("st_ls_err", 32'(ls_err), 1);
        chk("st_if_err", 32'(if_err), 0);
        step();
        mem_ack = 0; mem_err = 0; ls_req = 0; ls_wr = 0;
        settle();

        // Spurious ack in IDLE
        mem_ack = 1; mem_rdata = 32'h55;
        settle();
        chk("sp_if_ack",   32'(if_ack), 0);
        chk("sp_ls_ack",   32'(ls_ack), 0);
        chk("sp_ls_rdata", ls_rdata, 0);
        step();
        mem_ack = 0;
        settle();
        chk("sp_busy", 32'(busy), 0);

        // Reset in the middle of an LS grant
        ls_req = 1; ls_addr = 32'h4000;
        step(); settle();
        chk("rm_busy_pre",  32'(busy), 1);
        chk("rm_owner_pre", 32'(owner), 1);
        rst = 1;
        settle();
        chk("rm_mem_req", 32'(mem_req), 0);
        chk("rm_busy",    32'(busy), 0);
        chk("rm_owner",   32'(owner), 0);
        chk("rm_addr",    mem_addr, 0);
        mem_ack = 1;
        settle();
        chk("rm_ls_ack",  32'(ls_ack), 0);
        mem_ack = 0; ls_req = 0;
        step();
        rst = 0;
        step();

`ifdef RV32_ARB_TIMEOUT_EN
        // Watchdog fires on the 4th grant cycle
        ls_req = 1; ls_addr = 32'h5000; mem_rdata = 32'h77;
        for (int c = 1; c <= 4; c++) begin
            step(); settle();
            chk("to_ack", 32'(ls_ack), (c == 4) ? 32'd1 : 32'd0);
        end
        chk("to_err",   32'(ls_err), 1);
        chk("to_rdata", ls_rdata, 0);
        step();
        ls_req = 0; mem_ack = 1;
        settle();
        chk("to_late_ack", 32'(ls_ack), 0);
        chk("to_idle",     32'(busy), 0);
        step();
        mem_ack = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
